// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the PC generation stage.
//   state_t      : FSM states of pc_gen (S_FAULT is reachable only when
//                  PC_BOUNDS_CHECK_EN is defined).
//   RESET_PC_DEF : default PC loaded on reset.
//   PC_STEP_DEF  : default sequential increment (one instruction index).
package pc_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned PC_STEP_DEF  = 1;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational priority mux choosing the next fetch PC while
// the stage is running.
//   pc, pc_seq               : current PC and its sequential successor
//   br_redirect, br_target   : taken branch from EX (highest priority)
//   jmp_redirect, jmp_target : jump from ID
//   halt                     : halt decoded in ID
//   stall                    : downstream stall
//   pc_sel                   : selected next PC
//   state_hint               : S_HALT when the halt is accepted, else S_RUN
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_seq,
  input  logic             br_redirect,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_redirect,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             halt,
  input  logic             stall,
  output logic [WIDTH-1:0] pc_sel,
  output state_t           state_hint
);

  // Branch is the oldest instruction in flight, so it beats the jump, and
  // both redirects squash a younger halt and override a stall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    pc_sel     = pc_seq;
    state_hint = S_RUN;
    if (br_redirect) begin
      pc_sel = br_target;
    end else if (jmp_redirect) begin
      pc_sel = jmp_target;
    end else if (halt) begin
      pc_sel     = pc;
      state_hint = S_HALT;
    end else if (stall) begin
      pc_sel = pc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generation stage feeding instruction_fetch.
// Holds the fetch PC, steps it each cycle, applies branch/jump redirects,
// holds on stall and parks on halt. Reset is synchronous, active-low.
//   clk, rst_n      : clock, synchronous active-low reset
//   stall_i         : hold PC
//   br_redirect_i   : taken branch, target br_target_i
//   jmp_redirect_i  : jump, target jmp_target_i
//   halt_i          : halt decoded
//   pc_o            : current fetch PC (registered)
//   pc_next_seq_o   : pc_o + PC_STEP (combinational, link value)
//   pc_valid_o      : pc_o is a real fetch
//   halted_o        : core halted (also set on a bounds fault)
//   fetch_count_o   : number of accepted fetches, wraps
//   fault_o         : PC left the image; constant 0 unless the macro is set
// Optional feature macro: PC_BOUNDS_CHECK_EN enables the IMEM_DEPTH range
// check and the S_FAULT state.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] PC_STEP    = WIDTH'(PC_STEP_DEF),
  parameter int unsigned      IMEM_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             br_redirect_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_redirect_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             halt_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_seq_o,
  output logic             pc_valid_o,
  output logic             halted_o,
  output logic [WIDTH-1:0] fetch_count_o,
  output logic             fault_o
);

  state_t           state_q, state_next, sel_hint;
  logic [WIDTH-1:0] pc_q, pc_next, pc_sel, count_q;
  logic             valid_q, halted_q;

  assign pc_next_seq_o = pc_q + PC_STEP;

  pc_next_sel #(.WIDTH(WIDTH)) u_sel (
    .pc           (pc_q),
    .pc_seq       (pc_next_seq_o),
    .br_redirect  (br_redirect_i),
    .br_target    (br_target_i),
    .jmp_redirect (jmp_redirect_i),
    .jmp_target   (jmp_target_i),
    .halt         (halt_i),
    .stall        (stall_i),
    .pc_sel       (pc_sel),
    .state_hint   (sel_hint)
  );

`ifdef PC_BOUNDS_CHECK_EN
  logic fault_q;
  logic out_of_range;
  // Compare one bit wider so IMEM_DEPTH == 2**WIDTH stays representable.
  assign out_of_range = {1'b0, pc_sel} >= (WIDTH + 1)'(IMEM_DEPTH);
`endif

  always_comb begin
    state_next = state_q;
    pc_next    = pc_q;
    unique case (state_q)
      S_BOOT: state_next = S_RUN;
      S_RUN: begin
        state_next = sel_hint;
        pc_next    = pc_sel;
`ifdef PC_BOUNDS_CHECK_EN
        // Keep the last in-range PC rather than loading the bad one.
        if (out_of_range) begin
          state_next = S_FAULT;
          pc_next    = pc_q;
        end
`endif
      end
      default: ; // S_HALT / S_FAULT: frozen until reset
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the PC they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_next;
      pc_q     <= pc_next;
      valid_q  <= (state_next == S_RUN);
      halted_q <= (state_next == S_HALT) || (state_next == S_FAULT);
      // A stalled cycle issues nothing even if a redirect is applied.
      if (valid_q && !stall_i) count_q <= count_q + 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q  <= (state_next == S_FAULT);
`endif
    end
  end

  assign pc_o          = pc_q;
  assign pc_valid_o    = valid_q;
  assign halted_o      = halted_q;
  assign fetch_count_o = count_q;
`ifdef PC_BOUNDS_CHECK_EN
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. Directed scenarios followed by
// randomized stimulus, all compared against a behavioural model of the stage.
// Builds with or without PC_BOUNDS_CHECK_EN (IMEM_DEPTH=8 when defined).
module tb_pc_gen;

  localparam int unsigned WIDTH = 32;
`ifdef PC_BOUNDS_CHECK_EN
  localparam int unsigned DEPTH = 8;
  localparam bit          BOUNDS = 1'b1;
`else
  localparam int unsigned DEPTH = 1024;
  localparam bit          BOUNDS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, stall_i, br_redirect_i, jmp_redirect_i, halt_i;
  logic [WIDTH-1:0] br_target_i, jmp_target_i;
  logic [WIDTH-1:0] pc_o, pc_next_seq_o, fetch_count_o;
  logic             pc_valid_o, halted_o, fault_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_pc, m_cnt;
  bit               m_boot, m_valid, m_halted, m_fault;

  pc_gen #(.WIDTH(WIDTH), .RESET_PC('0), .PC_STEP(32'd1), .IMEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .br_redirect_i  (br_redirect_i),
    .br_target_i    (br_target_i),
    .jmp_redirect_i (jmp_redirect_i),
    .jmp_target_i   (jmp_target_i),
    .halt_i         (halt_i),
    .pc_o           (pc_o),
    .pc_next_seq_o  (pc_next_seq_o),
    .pc_valid_o     (pc_valid_o),
    .halted_o       (halted_o),
    .fetch_count_o  (fetch_count_o),
    .fault_o        (fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of the model: what the stage should show after this edge.
  task automatic model_edge(input bit rst, input bit st, input bit br,
                            input logic [WIDTH-1:0] bt, input bit jp,
                            input logic [WIDTH-1:0] jt, input bit hl);
    logic [WIDTH-1:0] want;
    if (!rst) begin
      m_pc = '0; m_cnt = '0; m_boot = 1; m_valid = 0; m_halted = 0; m_fault = 0;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (m_valid) begin
      if (!st) m_cnt = m_cnt + 1;
      if (br)      want = bt;
      else if (jp) want = jt;
      else if (hl || st) want = m_pc;
      else         want = m_pc + 1;
      if (hl && !br && !jp) begin
        m_valid = 0; m_halted = 1;
      end else if (BOUNDS && want >= DEPTH) begin
        m_valid = 0; m_halted = 1; m_fault = 1;
      end else begin
        m_pc = want;
      end
    end
  endtask

  task automatic compare_all();
    check("pc", pc_o, m_pc);
    check("pc_seq", pc_next_seq_o, m_pc + 1);
    check("valid", {31'd0, pc_valid_o}, {31'd0, m_valid});
    check("halted", {31'd0, halted_o}, {31'd0, m_halted});
    check("count", fetch_count_o, m_cnt);
    check("fault", {31'd0, fault_o}, {31'd0, m_fault});
  endtask

  // Drive inputs, advance one edge, compare #1 after the edge.
  task automatic step(input bit rst, input bit st, input bit br,
                      input logic [WIDTH-1:0] bt, input bit jp,
                      input logic [WIDTH-1:0] jt, input bit hl);
    rst_n = rst; stall_i = st; br_redirect_i = br; br_target_i = bt;
    jmp_redirect_i = jp; jmp_target_i = jt; halt_i = hl;
    model_edge(rst, st, br, bt, jp, jt, hl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, '0, 0, '0, 0);
    step(0, 0, 0, '0, 0, '0, 0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_valid", {31'd0, pc_valid_o}, 32'd0);
  endtask

  initial begin
    rst_n = 0; stall_i = 0; br_redirect_i = 0; jmp_redirect_i = 0; halt_i = 0;
    br_target_i = '0; jmp_target_i = '0;
    m_boot = 1; m_pc = '0; m_cnt = '0; m_valid = 0; m_halted = 0; m_fault = 0;

    // Reset, then free run: 0 (invalid), 0, 1, 2, 3.
    do_reset();
    idle();
    check("boot_valid", {31'd0, pc_valid_o}, 32'd1);
    check("boot_pc", pc_o, 32'd0);
    idle(); idle(); idle();
    check("run_pc3", pc_o, 32'd3);
    check("run_cnt3", fetch_count_o, 32'd3);

`ifndef PC_BOUNDS_CHECK_EN
    idle(); idle();
    check("pre_stall_pc5", pc_o, 32'd5);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0, '0, 0);
    check("stall_pc5", pc_o, 32'd5);
    check("stall_cnt", fetch_count_o, 32'd5);
    idle();
    check("unstall_pc6", pc_o, 32'd6);
    idle();
    // Branch + jump + stall at PC 7: branch wins, no count.
    step(1, 1, 1, 32'd40, 1, 32'd20, 0);
    check("prio_pc40", pc_o, 32'd40);
    check("prio_cnt", fetch_count_o, 32'd7);
    step(1, 0, 0, '0, 1, 32'd9, 0);
    check("jmp_pc9", pc_o, 32'd9);
    // Jump squashes a simultaneous halt.
    step(1, 0, 0, '0, 1, 32'd3, 1);
    check("jmp_halt_pc3", pc_o, 32'd3);
    check("jmp_halt_nohalt", {31'd0, halted_o}, 32'd0);
    step(1, 0, 0, '0, 0, '0, 1);
    check("halt_halted", {31'd0, halted_o}, 32'd1);
    check("halt_valid", {31'd0, pc_valid_o}, 32'd0);
    step(1, 0, 1, 32'd77, 1, 32'd55, 0);
    check("halt_frozen", pc_o, 32'd3);
    do_reset();
    check("halt_exit_pc", pc_o, 32'd0);
    // Wrap from the maximum PC to 0.
    idle();
    step(1, 0, 1, 32'hFFFF_FFFF, 0, '0, 0);
    idle();
    check("wrap_pc0", pc_o, 32'd0);
`else
    // Free run to 7, then the sequential step to 8 faults.
    idle(); idle(); idle(); idle();
    check("pre_fault_pc7", pc_o, 32'd7);
    idle();
    check("seq_fault", {31'd0, fault_o}, 32'd1);
    check("seq_fault_pc", pc_o, 32'd7);
    check("seq_fault_valid", {31'd0, pc_valid_o}, 32'd0);
    do_reset();
    idle(); idle(); idle();
    step(1, 0, 1, 32'd12, 0, '0, 0);
    check("br_fault", {31'd0, fault_o}, 32'd1);
    check("br_fault_pc", pc_o, 32'd2);
    do_reset();
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      bit               r, s, b, j, h;
      logic [WIDTH-1:0] bt, jt;
      r  = ($urandom_range(0, 99) >= 2);
      s  = ($urandom_range(0, 99) < 20);
      b  = ($urandom_range(0, 99) < 10);
      j  = ($urandom_range(0, 99) < 10);
      h  = ($urandom_range(0, 99) < 3);
      bt = BOUNDS ? WIDTH'($urandom_range(0, 11)) : WIDTH'($urandom());
      jt = BOUNDS ? WIDTH'($urandom_range(0, 11)) : WIDTH'($urandom());
      step(r, s, b, bt, j, jt, h);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
